// File: rtl/acia_rx_ctrl.sv
// acia_rx_ctrl: receive-side controller for the ACIA.
// Buffers bytes from the serial receive datapath in a FIFO, tracks framing,
// overrun and idle-timeout conditions as sticky flags, and exposes
// DATA / STATUS / CONTROL / COUNT registers to the 6502 bus.
//
// Ports:
//   clk     system clock
//   reset   synchronous active-high reset
//   pclk    peripheral tick enable (one-clk pulse per tick)
//   rx_dat  received byte, valid with rx_stb
//   rx_stb  one-clk strobe: good frame in rx_dat
//   rx_err  framing-error level, held until the next good frame
//   cs      register select
//   we      1 = write, 0 = read
//   addr    register address
//   din     CPU write data
//   dout    CPU read data, registered
//   irq     interrupt request, registered, active high
//
// Register map:
//   0 R  DATA    (pops FIFO when non-empty)
//   1 R  STATUS  {irq, 2'b00, FULL, TMO, OVR, FE, RDRF}; read clears FE/OVR/TMO
//   1 W  CONTROL {FLUSH, 4'b0, TMOIE, ERRIE, RXIE}; FLUSH is a strobe
//   2 R  COUNT
//   3 R  0
module acia_rx_ctrl #(
  parameter int AW        = 4,
  parameter int THRESH    = 1,
  parameter int TMW       = 16,
  parameter int TMO_TICKS = 40000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pclk,
  input  logic [7:0] rx_dat,
  input  logic       rx_stb,
  input  logic       rx_err,
  input  logic       cs,
  input  logic       we,
  input  logic [1:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       irq
);

  localparam logic [AW:0]    DEPTH    = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]    THR      = (AW+1)'(THRESH);
  localparam logic [TMW-1:0] TMO_MAX  = TMW'(TMO_TICKS);
  localparam logic [TMW-1:0] TMO_LAST = TMW'(TMO_TICKS - 1);

  logic [7:0]     mem [0:(1<<AW)-1];
  logic [AW-1:0]  wptr, rptr;
  logic [AW:0]    count;
  logic           fe, ovr, tmo;
  logic           rxie, errie, tmoie;
  logic           rx_err_q;
  logic [TMW-1:0] tmo_cnt;

  logic rd_en, wr_en, empty, full;
  logic pop, stat_rd, ctrl_wr, flush, push;
  logic ovr_set, fe_set, tmo_clr, tmo_set;
  logic [7:0] status;
  logic unused_din;

  assign unused_din = ^din[6:3];

  always_comb begin
    rd_en   = cs & ~we;
    wr_en   = cs & we;
    empty   = (count == '0);
    full    = (count == DEPTH);
    pop     = rd_en & (addr == 2'd0) & ~empty;
    stat_rd = rd_en & (addr == 2'd1);
    ctrl_wr = wr_en & (addr == 2'd1);
    flush   = ctrl_wr & din[7];
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    push    = rx_stb & (~full | pop) & ~flush;
    ovr_set = rx_stb & full & ~pop & ~flush;
    fe_set  = rx_err & ~rx_err_q;
    tmo_clr = push | pop | flush | empty;
    // Fires only on the tick that moves the counter onto TMO_MAX; once
    // saturated the counter never passes TMO_LAST again until cleared.
    tmo_set = pclk & ~tmo_clr & (tmo_cnt == TMO_LAST);
    status  = {irq, 2'b00, full, tmo, ovr, fe, ~empty};
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= rx_dat;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      fe       <= 1'b0;
      ovr      <= 1'b0;
      tmo      <= 1'b0;
      rxie     <= 1'b0;
      errie    <= 1'b0;
      tmoie    <= 1'b0;
      rx_err_q <= 1'b0;
      tmo_cnt  <= '0;
      irq      <= 1'b0;
      dout     <= 8'h00;
    end else begin
      rx_err_q <= rx_err;

      if (flush) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
      end else begin
        if (push) wptr <= wptr + 1'b1;
        if (pop)  rptr <= rptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end

      // Set beats the status-read clear; FLUSH clears unconditionally.
      if (flush) begin
        fe  <= 1'b0;
        ovr <= 1'b0;
        tmo <= 1'b0;
      end else begin
        fe  <= fe_set  | (fe  & ~stat_rd);
        ovr <= ovr_set | (ovr & ~stat_rd);
        tmo <= tmo_set | (tmo & ~stat_rd);
      end

      if (tmo_clr)
        tmo_cnt <= '0;
      else if (pclk && tmo_cnt != TMO_MAX)
        tmo_cnt <= tmo_cnt + 1'b1;

      if (ctrl_wr) begin
        rxie  <= din[0];
        errie <= din[1];
        tmoie <= din[2];
      end

      irq <= (rxie & (count >= THR)) | (errie & (fe | ovr)) | (tmoie & tmo);

      if (rd_en) begin
        case (addr)
          2'd0:    dout <= mem[rptr];
          2'd1:    dout <= status;
          2'd2:    dout <= 8'(count);
          default: dout <= 8'h00;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_acia_rx_ctrl.sv
// Self-checking bench for acia_rx_ctrl. CPU reads push their expected dout
// into a scoreboard queue; a monitor pops and compares one clk later.
module tb_acia_rx_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pclk = 1'b0;
  logic [7:0] rx_dat = 8'h00;
  logic       rx_stb = 1'b0;
  logic       rx_err = 1'b0;
  logic       cs = 1'b0;
  logic       we = 1'b0;
  logic [1:0] addr = 2'd0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic       irq;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] exp_q[$];
  string      nm_q[$];
  logic       rd_seen = 1'b0;

  acia_rx_ctrl #(.AW(4), .THRESH(1), .TMW(16), .TMO_TICKS(10)) dut (
    .clk(clk), .reset(reset), .pclk(pclk), .rx_dat(rx_dat), .rx_stb(rx_stb),
    .rx_err(rx_err), .cs(cs), .we(we), .addr(addr), .din(din),
    .dout(dout), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: a read sampled at a posedge presents dout at the next negedge.
  always @(posedge clk) rd_seen <= cs & ~we & ~reset;

  always @(negedge clk) begin
    if (rd_seen) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_underflow: got read with dout=0x%0h expected none", dout);
      end else begin
        chk(nm_q.pop_front(), int'(dout), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic cyc(); @(negedge clk); endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic rx(input logic [7:0] b);
    rx_dat = b; rx_stb = 1'b1; cyc(); rx_stb = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [7:0] e, input string nm);
    exp_q.push_back(e); nm_q.push_back(nm);
    cs = 1'b1; we = 1'b0; addr = a; cyc(); cs = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cs = 1'b1; we = 1'b1; addr = a; din = d; cyc(); cs = 1'b0; we = 1'b0;
  endtask

  task automatic fill16();
    for (int i = 0; i < 16; i++) rx(8'(i));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) cyc();
    reset = 1'b0;
    chk("reset_dout", int'(dout), 0);
    chk("reset_irq", int'(irq), 0);
    rd(2'd1, 8'h00, "reset_status");
    rd(2'd2, 8'h00, "reset_count");

    // Three bytes in, three bytes out.
    rx(8'h41); rx(8'h42); rx(8'h43);
    rd(2'd2, 8'h03, "t1_count");
    rd(2'd1, 8'h01, "t1_status");
    rd(2'd0, 8'h41, "t1_data0");
    rd(2'd0, 8'h42, "t1_data1");
    rd(2'd0, 8'h43, "t1_data2");
    rd(2'd1, 8'h00, "t1_status_empty");
    rd(2'd3, 8'h00, "t1_addr3");

    // Overrun: 17th byte dropped.
    fill16();
    rx(8'hAA);
    rd(2'd1, 8'h15, "t2_status_ovr");
    rd(2'd1, 8'h11, "t2_status_clr");
    for (int i = 0; i < 16; i++) rd(2'd0, 8'(i), "t2_data");
    rd(2'd1, 8'h00, "t2_status_empty");

    // Full FIFO with simultaneous pop and push.
    fill16();
    rx_dat = 8'h55; rx_stb = 1'b1;
    rd(2'd0, 8'h00, "t3_pop_push");
    rx_stb = 1'b0;
    rd(2'd2, 8'h10, "t3_count");
    rd(2'd1, 8'h11, "t3_status_no_ovr");
    for (int i = 1; i < 16; i++) rd(2'd0, 8'(i), "t3_data");
    rd(2'd0, 8'h55, "t3_data_last");
    rd(2'd1, 8'h00, "t3_status_empty");

    // Framing error edge detect, held level.
    wr(2'd1, 8'h02);
    rx_err = 1'b1;
    cyc();
    chk("t4_irq_lag", int'(irq), 0);
    cyc();
    chk("t4_irq_fe", int'(irq), 1);
    rd(2'd1, 8'h82, "t4_status_fe");
    rd(2'd1, 8'h80, "t4_status_fe_clr");
    rd(2'd1, 8'h00, "t4_status_quiet");
    idle(95);
    chk("t4_irq_held", int'(irq), 0);
    rx_err = 1'b0;
    cyc();
    rd(2'd1, 8'h00, "t4_status_after");
    wr(2'd1, 8'h00);

    // Idle timeout.
    wr(2'd1, 8'h04);
    rx(8'h77);
    pclk = 1'b1;
    idle(10);
    pclk = 1'b0;
    chk("t5_irq_lag", int'(irq), 0);
    cyc();
    chk("t5_irq_tmo", int'(irq), 1);
    pclk = 1'b1;
    idle(20);
    pclk = 1'b0;
    rd(2'd1, 8'h89, "t5_status_tmo");
    pclk = 1'b1;
    idle(20);
    pclk = 1'b0;
    chk("t5_irq_cleared", int'(irq), 0);
    rd(2'd1, 8'h01, "t5_status_no_reset");
    rd(2'd0, 8'h77, "t5_data");
    wr(2'd1, 8'h00);

    // Reset mid-operation.
    rx(8'h10); rx(8'h11);
    rd(2'd0, 8'h10, "t6_data_pre");
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("t6_dout_reset", int'(dout), 0);
    chk("t6_irq_reset", int'(irq), 0);
    rd(2'd2, 8'h00, "t6_count");

    // FLUSH with coincident push.
    wr(2'd1, 8'h01);
    for (int i = 0; i < 5; i++) rx(8'hC0 + 8'(i));
    chk("t7_irq_rx", int'(irq), 1);
    rx_dat = 8'hEE; rx_stb = 1'b1;
    wr(2'd1, 8'h81);
    rx_stb = 1'b0;
    chk("t7_irq_lag", int'(irq), 1);
    cyc();
    chk("t7_irq_off", int'(irq), 0);
    rd(2'd2, 8'h00, "t7_count");
    rd(2'd1, 8'h00, "t7_status");
    rx(8'h12);
    rd(2'd0, 8'h12, "t7_data_after_flush");

    idle(3);
    chk("sb_drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
